// File: rtl/dcache.sv
// rtl/dcache.sv - direct-mapped, write-through, no-write-allocate data cache
// A load miss fills the whole line beat by beat. Every store goes straight to backing memory.
module dcache #(
   parameter int WIDTH = 32,
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   input  logic             req_we,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   input  logic [3:0]       req_be,
   output logic             req_ready,
   output logic [WIDTH-1:0] rdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic [3:0]       mem_be,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = WIDTH - IDX_W - OFF_W - 2;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;

   logic [1:0]       state;
   logic [OFF_W-1:0] beat;
   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_array  [LINES];
   logic [WIDTH-1:0] data_array [LINES][WORDS];

   logic [OFF_W-1:0] offset;
   logic [IDX_W-1:0] index;
   logic [TAG_W-1:0] tag;
   logic             hit;
   logic             last_beat;
   logic [WIDTH-1:0] merged;
   logic             unused_addr_bits;

   assign offset    = req_addr[OFF_W+1:2];
   assign index     = req_addr[OFF_W+2 +: IDX_W];
   assign tag       = req_addr[WIDTH-1 -: TAG_W];
   assign hit       = valid[index] && (tag_array[index] == tag);
   assign last_beat = (beat == OFF_W'(WORDS - 1));
   assign rdata     = data_array[index][offset];
   assign unused_addr_bits = ^req_addr[1:0];

   always_comb begin
      merged = data_array[index][offset];
      for (int b = 0; b < 4; b++) begin
         if (req_be[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
      end
   end

   // The request is held by the pipeline, so addresses are built from req_* directly.
   always_comb begin
      req_ready = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = 4'h0;
      case (state)
         IDLE: req_ready = !req_valid || (!req_we && hit);
         FILL: begin
            mem_req  = 1'b1;
            mem_be   = 4'hF;
            mem_addr = {tag, index, beat, 2'b00};
         end
         WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {req_addr[WIDTH-1:2], 2'b00};
            mem_wdata = req_wdata;
            mem_be    = req_be;
            req_ready = mem_ack;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         beat  <= '0;
         valid <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_we) begin
                     state <= WRITE;
                  end else if (!hit) begin
                     valid[index] <= 1'b0;
                     beat         <= '0;
                     state        <= FILL;
                  end
               end
            end
            FILL: begin
               if (mem_ack) begin
                  beat <= beat + 1'b1;
                  if (last_beat) begin
                     valid[index] <= 1'b1;
                     state        <= IDLE;
                  end
               end
            end
            WRITE: if (mem_ack) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Storage arrays carry no reset; the valid bits alone qualify their contents.
   always_ff @(posedge clk) begin
      if (state == FILL && mem_ack) begin
         data_array[index][beat] <= mem_rdata;
         if (last_beat) tag_array[index] <= tag;
      end
      if (state == WRITE && mem_ack && hit) begin
         data_array[index][offset] <= merged;
      end
   end

endmodule

// File: tb/tb_dcache.sv
// tb/tb_dcache.sv - bench for dcache: directed vector table, reset abort, random accesses
// Backing memory is a bench array; the cache model is a per-index resident-tag table.
module tb_dcache;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   dcache #(.WIDTH(32), .LINES(16), .WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [4096];
   logic [31:0] fill_q [$];
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_be;
   int          n_rd = 0, n_wr = 0, wait_cnt = 0;
   bit          rand_delay = 0;
   int          n_cmp = 0, n_bad = 0;

   // Backing memory: answers one beat per request, optionally after random wait cycles.
   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req && !rst) begin
            if (wait_cnt > 0) begin
               wait_cnt--;
            end else begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b]) mem[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                  wr_addr = mem_addr; wr_data = mem_wdata; wr_be = mem_be;
                  n_wr++;
               end else begin
                  mem_rdata = mem[mem_addr[13:2]];
                  fill_q.push_back(mem_addr);
                  n_rd++;
               end
               wait_cnt = rand_delay ? int'($urandom_range(0, 2)) : 0;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rd, output int cyc,
                            output int reads, output int writes);
      int r0, w0;
      r0 = n_rd; w0 = n_wr;
      fill_q.delete();
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      cyc = 0;
      #1;
      while (!req_ready && cyc < 200) begin
         @(negedge clk); #1;
         cyc++;
      end
      if (!req_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL access_timeout: addr %h never completed", addr);
      end
      rd = rdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      reads = n_rd - r0;
      writes = n_wr - w0;
   endtask

   task automatic check_fill(input string name, input logic [31:0] addr);
      for (int k = 0; k < 4; k++)
         check($sformatf("%s_beat%0d", name, k), (k < fill_q.size()) ? fill_q[k] : 32'hx,
               {addr[31:4], 4'h0} + 32'(4 * k));
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      int          exp_cyc;
      int          exp_rd;
      int          exp_wr;
   } vec_t;

   vec_t        vecs [9];
   int          resident [16];
   logic [31:0] rd, addr, wdata, exp;
   logic [3:0]  be;
   logic        we;
   int          cyc, nr, nw, r0;

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
      mem[16'h10] = 32'h11; mem[16'h11] = 32'h22; mem[16'h12] = 32'h33; mem[16'h13] = 32'h44;

      vecs[0] = '{1'b0, 32'h40,   32'h0,        4'h0, 32'h11,        5, 4, 0};
      vecs[1] = '{1'b0, 32'h48,   32'h0,        4'h0, 32'h33,        0, 0, 0};
      vecs[2] = '{1'b1, 32'h44,   32'hAABBCCDD, 4'h3, 32'h0,         1, 0, 1};
      vecs[3] = '{1'b0, 32'h44,   32'h0,        4'h0, 32'h0000CCDD,  0, 0, 0};
      vecs[4] = '{1'b1, 32'h1000, 32'h12345678, 4'h6, 32'h0,         1, 0, 1};
      vecs[5] = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'hC0345600,  5, 4, 0};
      vecs[6] = '{1'b0, 32'h140,  32'h0,        4'h0, 32'hC0DE0050,  5, 4, 0};
      vecs[7] = '{1'b0, 32'h40,   32'h0,        4'h0, 32'h11,        5, 4, 0};
      vecs[8] = '{1'b0, 32'h4C,   32'h0,        4'h0, 32'h44,        0, 0, 0};

      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, cyc, nr, nw);
         check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
         check($sformatf("v%0d_reads", i), 32'(nr), 32'(vecs[i].exp_rd));
         check($sformatf("v%0d_writes", i), 32'(nw), 32'(vecs[i].exp_wr));
         if (!vecs[i].we) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
         else begin
            check($sformatf("v%0d_wr_addr", i), wr_addr, {vecs[i].addr[31:2], 2'b00});
            check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].wdata);
            check($sformatf("v%0d_wr_be", i), 32'(wr_be), 32'(vecs[i].be));
         end
         if (vecs[i].exp_rd == 4) check_fill($sformatf("v%0d_fill", i), vecs[i].addr);
      end

      // Reset after two fill beats: the partial line must not survive.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h200;
      r0 = n_rd;
      for (int t = 0; t < 20 && (n_rd - r0) < 2; t++) begin
         @(negedge clk); #1;
      end
      check("abort_beats_before_rst", 32'(n_rd - r0), 32'd2);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("abort_mem_req", 32'(mem_req), 32'd0);
      check("abort_mem_addr", mem_addr, 32'h0);
      req_valid = 1'b0;
      #1;
      check("abort_req_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_access(1'b0, 32'h200, 32'h0, 4'h0, rd, cyc, nr, nw);
      check("refetch_reads", 32'(nr), 32'd4);
      check("refetch_cycles", 32'(cyc), 32'd5);
      check("refetch_rdata", rd, 32'hC0DE0080);
      check_fill("refetch_fill", 32'h200);
      do_access(1'b0, 32'h40, 32'h0, 4'h0, rd, cyc, nr, nw);
      check("post_rst_0x40_reads", 32'(nr), 32'd4);
      check("post_rst_0x40_rdata", rd, 32'h11);

      // Random traffic over 4 tags x 16 lines with random memory latency.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) resident[i] = -1;
      rand_delay = 1;
      for (int n = 0; n < 300; n++) begin
         we = ($urandom_range(0, 3) == 0);
         addr = {22'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         wdata = $urandom;
         be = 4'($urandom_range(0, 15));
         exp = mem[addr[13:2]];
         do_access(we, addr, wdata, be, rd, cyc, nr, nw);
         if (we) begin
            check($sformatf("r%0d_st_writes", n), 32'(nw), 32'd1);
            check($sformatf("r%0d_st_reads", n), 32'(nr), 32'd0);
            check($sformatf("r%0d_st_addr", n), wr_addr, {addr[31:2], 2'b00});
            check($sformatf("r%0d_st_be", n), 32'(wr_be), 32'(be));
         end else begin
            check($sformatf("r%0d_ld_reads", n), 32'(nr),
                  (resident[addr[7:4]] == int'(addr[31:8])) ? 32'd0 : 32'd4);
            check($sformatf("r%0d_ld_rdata", n), rd, exp);
            resident[addr[7:4]] = int'(addr[31:8]);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
